multicycle_control_unit: RTL and testbench

Sequencing control unit for the multi-cycle RV32 core: a FETCH/DECODE/EXEC/MEM/WB state machine that drives fetch, data-memory and writeback enables and emits the ALU op code. It extends the R-type-only combinational decoder to I-ALU, load, store and BEQ/BNE, with SUB/SRA/SLT/MUL disambiguation, memory-ready handshakes with timeout, an illegal-instruction trap, and a retired-instruction counter. Sits between the instruction register, register file, ALU and the two memory ports.

---
 rtl/multicycle_control_unit_if.sv | 20 ++
 rtl/multicycle_control_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Memory-side handshake bundle for the multi-cycle control unit.
// The control unit is the master; the fetch/data memory ports are the slave.
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ready;
  logic ir_en;
  logic dmem_req;
  logic dmem_ready;
  logic dmem_we;

  modport master (
    output imem_req, ir_en, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, ir_en, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32 core.
// Decodes R, I-ALU, LW, SW, BEQ/BNE; traps on illegal ops and ready timeouts.
module multicycle_control_unit #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  multicycle_control_unit_if.master mem,
  output logic [3:0]       alu_op,
  output logic             alu_src_b,
  output logic             wb_sel,
  output logic             reg_write_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_retired
);

  if (TIMEOUT < 1 || N < 1 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_control_unit: bad parameter");
  end

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_BR
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d;
  logic       bne_q, bne_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       src_q, src_d;
  logic       wb_q, wb_d;
  logic       trap_q, trap_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       dec_ok, dec_src, dec_wb, dec_bne;
  logic [3:0] dec_op;
  cls_t       dec_cls;

  logic imem_req, ir_en, dmem_req, dmem_we;

  // Instruction decode from the IR fields.
  always_comb begin
    dec_ok  = 1'b0;
    dec_op  = OP_ADD;
    dec_src = 1'b0;
    dec_wb  = 1'b0;
    dec_cls = C_R;
    dec_bne = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        dec_ok = 1'b1;
        unique case ({funct7, funct3})
          {7'h00, 3'b000}: dec_op = OP_ADD;
          {7'h20, 3'b000}: dec_op = OP_SUB;
          {7'h01, 3'b000}: dec_op = OP_MUL;
          {7'h00, 3'b001}: dec_op = OP_SLL;
          {7'h00, 3'b010}: dec_op = OP_SLT;
          {7'h00, 3'b100}: dec_op = OP_XOR;
          {7'h00, 3'b101}: dec_op = OP_SRL;
          {7'h20, 3'b101}: dec_op = OP_SRA;
          {7'h00, 3'b110}: dec_op = OP_OR;
          {7'h00, 3'b111}: dec_op = OP_AND;
          default:         dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_cls = C_I;
        dec_src = 1'b1;
        dec_ok  = 1'b1;
        unique case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            dec_op = OP_SLL;
            dec_ok = (funct7 == 7'h00);
          end
          3'b101: begin
            dec_op = funct7[5] ? OP_SRA : OP_SRL;
            dec_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_cls = C_LD;
        dec_src = 1'b1;
        dec_wb  = 1'b1;
        dec_ok  = (funct3 == 3'b010);
      end
      7'b0100011: begin
        dec_cls = C_ST;
        dec_src = 1'b1;
        dec_ok  = (funct3 == 3'b010);
      end
      7'b1100011: begin
        dec_cls = C_BR;
        dec_op  = OP_SUB;
        dec_bne = funct3[0];
        dec_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next-state, handshake timeouts and per-state enables.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    bne_d    = bne_q;
    wait_d   = wait_q;
    alu_op_d = alu_op_q;
    src_d    = src_q;
    wb_d     = wb_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    imem_req     = 1'b0;
    ir_en        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == W_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          state_d  = S_EXEC;
          cls_d    = dec_cls;
          bne_d    = dec_bne;
          alu_op_d = dec_op;
          src_d    = dec_src;
          wb_d     = dec_wb;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        wait_d = '0;
        unique case (cls_q)
          C_LD, C_ST: state_d = S_MEM;
          C_BR: begin
            pc_en   = 1'b1;
            pc_sel  = bne_q ? !alu_zero : alu_zero;
            state_d = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_ST);
        if (mem.dmem_ready) begin
          wait_d = '0;
          if (cls_q == C_ST) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == W_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_WB: begin
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
        wait_d       = '0;
        state_d      = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      imem_req     = 1'b0;
      ir_en        = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_write_en = 1'b0;
      pc_en        = 1'b0;
      pc_sel       = 1'b0;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pc_en};
  end

  // State and held decode/trap/counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      cls_q    <= C_R;
      bne_q    <= 1'b0;
      wait_q   <= '0;
      alu_op_q <= 4'b0000;
      src_q    <= 1'b0;
      wb_q     <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      bne_q    <= bne_d;
      wait_q   <= wait_d;
      alu_op_q <= alu_op_d;
      src_q    <= src_d;
      wb_q     <= wb_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem.imem_req = imem_req;
  assign mem.ir_en    = ir_en;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;

  assign alu_op        = alu_op_q;
  assign alu_src_b     = src_q;
  assign wb_sel        = wb_q;
  assign trap          = trap_q;
  assign trap_cause    = cause_q;
  assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (TIMEOUT=16, CNT_W=4).
// Runs one instruction per call and checks cycle positions of the pulses.
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero;
  logic [3:0] alu_op;
  logic       alu_src_b, wb_sel, reg_write_en, pc_en, pc_sel, trap;
  logic [1:0] trap_cause;
  logic [3:0] instr_retired;

  multicycle_control_unit_if m();

  multicycle_control_unit #(.N(32), .TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .mem(m),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
    .reg_write_en(reg_write_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause),
    .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_bad = 0;
  int r_pc, r_rwe, r_trap, n_ireq, n_dreq, n_dwe, n_rwe, n_ir;
  logic r_sel, r_src, r_wb;
  logic [3:0] r_op;
  logic [3:0] r_ret;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one instruction; stops at pc_en, trap or the cycle budget.
  task automatic run(input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic z,
                     input int idly, input int ddly, input int lim);
    opcode = op; funct3 = f3; funct7 = f7; alu_zero = z;
    r_pc = 0; r_rwe = 0; r_trap = 0;
    n_ireq = 0; n_dreq = 0; n_dwe = 0; n_rwe = 0; n_ir = 0;
    r_sel = 0; r_src = 0; r_wb = 0; r_op = 0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (m.imem_req) n_ireq++;
      if (m.dmem_req) n_dreq++;
      m.imem_ready = m.imem_req && (n_ireq > idly);
      m.dmem_ready = m.dmem_req && (n_dreq > ddly);
      #1;
      if (m.ir_en) n_ir++;
      if (m.dmem_we) n_dwe++;
      if (reg_write_en) begin n_rwe++; r_rwe = c; end
      if (reg_write_en && m.dmem_we) n_bad++;
      if (pc_en) begin
        r_pc = c; r_sel = pc_sel; r_op = alu_op;
        r_src = alu_src_b; r_wb = wb_sel;
      end
      if (trap) r_trap = c;
      if (pc_en || trap) break;
    end
    @(posedge clk); #1;
    m.imem_ready = 1'b0;
    m.dmem_ready = 1'b0;
    r_ret = instr_retired;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;
  localparam logic [6:0] B_OP = 7'b1100011;

  initial begin
    rst = 1'b1;
    opcode = 0; funct3 = 0; funct7 = 0; alu_zero = 0;
    m.imem_ready = 1'b0;
    m.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", m.imem_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_trap", {trap, trap_cause}, 0);
    chk("rst_retired", instr_retired, 0);
    rst = 1'b0;

    run(R_OP, 3'b000, 7'h00, 0, 0, 0, 30);
    chk("add_pc_cyc", r_pc, 4);
    chk("add_rwe_cyc", r_rwe, 4);
    chk("add_op", r_op, 4'b0010);
    chk("add_ir_en", n_ir, 1);
    chk("add_src", r_src, 0);

    run(R_OP, 3'b000, 7'h20, 0, 0, 0, 30);
    chk("sub_op", r_op, 4'b0100);
    chk("sub_rwe_cyc", r_rwe, 4);
    chk("sub_retired", r_ret, 2);

    run(B_OP, 3'b000, 7'h00, 1, 0, 0, 30);
    chk("beq_pc_cyc", r_pc, 3);
    chk("beq_sel", r_sel, 1);
    chk("beq_op", r_op, 4'b0100);
    chk("beq_no_wr", n_rwe + n_dreq, 0);

    run(B_OP, 3'b001, 7'h00, 1, 0, 0, 30);
    chk("bne_pc_cyc", r_pc, 3);
    chk("bne_sel", r_sel, 0);
    chk("bne_no_wr", n_rwe + n_dreq, 0);

    run(L_OP, 3'b010, 7'h00, 0, 0, 3, 30);
    chk("lw_dreq_cycles", n_dreq, 4);
    chk("lw_no_we", n_dwe, 0);
    chk("lw_wb_sel", r_wb, 1);
    chk("lw_rwe_cyc", r_rwe, 8);
    chk("lw_pc_cyc", r_pc, 8);
    chk("lw_src", r_src, 1);

    run(S_OP, 3'b010, 7'h00, 0, 0, 0, 30);
    chk("sw_we", n_dwe, 1);
    chk("sw_no_rwe", n_rwe, 0);
    chk("sw_pc_cyc", r_pc, 4);
    chk("sw_retired", r_ret, 6);

    run(R_OP, 3'b000, 7'h01, 0, 0, 0, 30);
    chk("mul_op", r_op, 4'b0110);
    run(I_OP, 3'b101, 7'h20, 0, 0, 0, 30);
    chk("srai_op", {r_src, r_op}, 5'b1_1000);
    run(I_OP, 3'b110, 7'h7f, 0, 0, 0, 30);
    chk("ori_op", {r_src, r_op}, 5'b1_0001);
    chk("ori_retired", r_ret, 9);

    run(R_OP, 3'b000, 7'h00, 0, 15, 0, 40);
    chk("late_ireq", n_ireq, 16);
    chk("late_pc_cyc", r_pc, 19);
    chk("late_no_trap", r_trap, 0);
    chk("late_retired", r_ret, 10);

    for (int k = 0; k < 6; k++) run(R_OP, 3'b000, 7'h00, 0, 0, 0, 30);
    chk("wrap_retired", r_ret, 0);

    run(R_OP, 3'b000, 7'h00, 0, 100, 0, 40);
    chk("ito_ireq", n_ireq, 16);
    chk("ito_trap_cyc", r_trap, 17);
    chk("ito_cause", {trap, trap_cause}, 3'b110);
    chk("ito_frozen", r_ret, 0);

    do_reset();
    run(7'h7f, 3'b000, 7'h00, 0, 0, 0, 10);
    chk("ill_trap_cyc", r_trap, 3);
    chk("ill_cause", {trap, trap_cause}, 3'b101);
    chk("ill_no_pc", r_pc + n_rwe, 0);
    run(R_OP, 3'b000, 7'h00, 0, 0, 0, 3);
    chk("ill_quiet", n_ireq + n_ir + r_pc, 0);
    chk("ill_frozen", r_ret, 0);

    do_reset();
    run(R_OP, 3'b000, 7'h02, 0, 0, 0, 10);
    chk("ilr_trap_cyc", r_trap, 3);
    chk("ilr_cause", trap_cause, 2'b01);

    do_reset();
    run(S_OP, 3'b010, 7'h00, 0, 0, 100, 5);
    chk("swr_we_cycles", n_dwe, 2);
    chk("swr_we_pre", m.dmem_we, 1);
    rst = 1'b1;
    #1;
    chk("swr_rst_out",
        {m.dmem_we, m.dmem_req, m.imem_req, pc_en, reg_write_en}, 0);
    @(posedge clk); #1;
    chk("swr_rst_we", m.dmem_we, 0);
    rst = 1'b0;
    #1;
    chk("swr_fetch", m.imem_req, 1);
    run(R_OP, 3'b000, 7'h00, 0, 0, 0, 30);
    chk("swr_add_pc", r_pc, 4);
    chk("swr_retired", r_ret, 1);

    chk("we_rwe_excl", n_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
